// File: rtl/radix_butterfly_cfg.sv
// radix_butterfly_cfg
// Configurable, fully pipelined FFT butterfly. Each accepted set of four
// complex samples is processed either as one radix-4 butterfly or as two
// independent radix-2 butterflies, forward or inverse. The result is
// rounded-shifted by 0/1/2 bits and saturated to OUT_WIDTH. A global stall
// freezes the whole pipeline. mode/inverse/scale travel with their set, so
// the configuration can change on every set without a bubble.
//
// Pipeline (3 register stages, out_valid follows the accept edge by two
// more unstalled edges):
//   S1: operands + raw twiddle products
//   S2: rounded products + first-level add/sub
//   S3: final combine, scale, saturate -> Q outputs
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   stall            freeze every pipeline register (ovf_clr still honoured)
//   in_valid         input set valid (ignored while stall=1)
//   mode             0 = radix-4, 1 = dual radix-2
//   inverse          1 = conjugate twiddles and swap the +/-j terms
//   scale            rounding right shift 0/1/2 (3 behaves as 2)
//   A..D _r/_i       input samples, WIDTH signed
//   W0..W2 _r/_i     twiddles for B, C, D, Q1.(TW_WIDTH-1)
//   ovf_clr          clear sticky overflow
//   out_valid        result valid
//   Q0..Q3 _r/_i     results, OUT_WIDTH signed
//   ovf              sticky saturation flag
module radix_butterfly_cfg #(
  parameter int WIDTH     = 26,
  parameter int TW_WIDTH  = 16,
  parameter int OUT_WIDTH = WIDTH + 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        in_valid,
  input  logic                        mode,
  input  logic                        inverse,
  input  logic [1:0]                  scale,
  input  logic signed [WIDTH-1:0]     A_r,
  input  logic signed [WIDTH-1:0]     A_i,
  input  logic signed [WIDTH-1:0]     B_r,
  input  logic signed [WIDTH-1:0]     B_i,
  input  logic signed [WIDTH-1:0]     C_r,
  input  logic signed [WIDTH-1:0]     C_i,
  input  logic signed [WIDTH-1:0]     D_r,
  input  logic signed [WIDTH-1:0]     D_i,
  input  logic signed [TW_WIDTH-1:0]  W0_r,
  input  logic signed [TW_WIDTH-1:0]  W0_i,
  input  logic signed [TW_WIDTH-1:0]  W1_r,
  input  logic signed [TW_WIDTH-1:0]  W1_i,
  input  logic signed [TW_WIDTH-1:0]  W2_r,
  input  logic signed [TW_WIDTH-1:0]  W2_i,
  input  logic                        ovf_clr,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] Q0_r,
  output logic signed [OUT_WIDTH-1:0] Q0_i,
  output logic signed [OUT_WIDTH-1:0] Q1_r,
  output logic signed [OUT_WIDTH-1:0] Q1_i,
  output logic signed [OUT_WIDTH-1:0] Q2_r,
  output logic signed [OUT_WIDTH-1:0] Q2_i,
  output logic signed [OUT_WIDTH-1:0] Q3_r,
  output logic signed [OUT_WIDTH-1:0] Q3_i,
  output logic                        ovf
);

  // rounded product width, internal sum width, raw product width
  localparam int PW = WIDTH + 2;
  localparam int SW = WIDTH + 4;
  localparam int RW = WIDTH + TW_WIDTH + 2;

  localparam logic signed [SW-1:0] Q_MAX = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] Q_MIN = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Operands are widened before negation so that conjugating a twiddle of
  // -2^(TW_WIDTH-1) cannot wrap.
  function automatic void cmul(
    input  logic signed [WIDTH-1:0]    x_r,
    input  logic signed [WIDTH-1:0]    x_i,
    input  logic signed [TW_WIDTH-1:0] w_r,
    input  logic signed [TW_WIDTH-1:0] w_i,
    input  logic                       conj,
    output logic signed [RW-1:0]       p_r,
    output logic signed [RW-1:0]       p_i
  );
    logic signed [RW-1:0] xr, xi, wr, wi;
    xr  = RW'(x_r);
    xi  = RW'(x_i);
    wr  = RW'(w_r);
    wi  = conj ? -RW'(w_i) : RW'(w_i);
    p_r = xr * wr - xi * wi;
    p_i = xr * wi + xi * wr;
  endfunction

  function automatic logic signed [PW-1:0] rnd(input logic signed [RW-1:0] raw);
    logic signed [RW-1:0] t;
    t = (raw + (RW'(1) <<< (TW_WIDTH - 2))) >>> (TW_WIDTH - 1);
    return t[PW-1:0];
  endfunction

  // ---------------- S1 ----------------
  logic signed [RW-1:0] b_raw_r, b_raw_i, c_raw_r, c_raw_i, d_raw_r, d_raw_i;

  always_comb begin
    cmul(B_r, B_i, W0_r, W0_i, inverse, b_raw_r, b_raw_i);
    cmul(C_r, C_i, W1_r, W1_i, inverse, c_raw_r, c_raw_i);
    cmul(D_r, D_i, W2_r, W2_i, inverse, d_raw_r, d_raw_i);
  end

  logic                    s1_valid, s1_mode, s1_inv;
  logic [1:0]              s1_scale;
  logic signed [WIDTH-1:0] s1_a_r, s1_a_i, s1_c_r, s1_c_i;
  logic signed [RW-1:0]    s1_b_r, s1_b_i, s1_cw_r, s1_cw_i, s1_d_r, s1_d_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode  <= mode;
        s1_inv   <= inverse;
        s1_scale <= scale;
        s1_a_r   <= A_r;
        s1_a_i   <= A_i;
        s1_c_r   <= C_r;
        s1_c_i   <= C_i;
        s1_b_r   <= b_raw_r;
        s1_b_i   <= b_raw_i;
        s1_cw_r  <= c_raw_r;
        s1_cw_i  <= c_raw_i;
        s1_d_r   <= d_raw_r;
        s1_d_i   <= d_raw_i;
      end
    end
  end

  // ---------------- S2 ----------------
  // Radix-4 pairs a with c and b with d; dual radix-2 pairs a with b and
  // c with d. The operand swap lets both modes share one adder set.
  logic signed [SW-1:0] a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;
  logic signed [SW-1:0] x_r, x_i, y_r, y_i;
  logic signed [SW-1:0] n_u0_r, n_u0_i, n_u1_r, n_u1_i, n_u2_r, n_u2_i, n_u3_r, n_u3_i;

  always_comb begin
    a_r = SW'(s1_a_r);
    a_i = SW'(s1_a_i);
    b_r = SW'(rnd(s1_b_r));
    b_i = SW'(rnd(s1_b_i));
    c_r = s1_mode ? SW'(s1_c_r) : SW'(rnd(s1_cw_r));
    c_i = s1_mode ? SW'(s1_c_i) : SW'(rnd(s1_cw_i));
    d_r = SW'(rnd(s1_d_r));
    d_i = SW'(rnd(s1_d_i));
    x_r = s1_mode ? b_r : c_r;
    x_i = s1_mode ? b_i : c_i;
    y_r = s1_mode ? c_r : b_r;
    y_i = s1_mode ? c_i : b_i;
    n_u0_r = a_r + x_r;
    n_u0_i = a_i + x_i;
    n_u1_r = a_r - x_r;
    n_u1_i = a_i - x_i;
    n_u2_r = y_r + d_r;
    n_u2_i = y_i + d_i;
    n_u3_r = y_r - d_r;
    n_u3_i = y_i - d_i;
  end

  logic                 s2_valid, s2_mode, s2_inv;
  logic [1:0]           s2_scale;
  logic signed [SW-1:0] u0_r, u0_i, u1_r, u1_i, u2_r, u2_i, u3_r, u3_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mode  <= s1_mode;
        s2_inv   <= s1_inv;
        s2_scale <= s1_scale;
        u0_r <= n_u0_r;
        u0_i <= n_u0_i;
        u1_r <= n_u1_r;
        u1_i <= n_u1_i;
        u2_r <= n_u2_r;
        u2_i <= n_u2_i;
        u3_r <= n_u3_r;
        u3_i <= n_u3_i;
      end
    end
  end

  // ---------------- S3 ----------------
  // Index order: Q0_r, Q0_i, Q1_r, Q1_i, Q2_r, Q2_i, Q3_r, Q3_i
  logic signed [SW-1:0]        s3_sum [8];
  logic signed [SW-1:0]        s3_scl [8];
  logic signed [OUT_WIDTH-1:0] s3_q   [8];
  logic [7:0]                  s3_clip;
  logic                        ovf_set;

  always_comb begin
    for (int i = 0; i < 8; i++) s3_sum[i] = '0;
    if (s2_mode) begin
      s3_sum[0] = u0_r;
      s3_sum[1] = u0_i;
      s3_sum[2] = u1_r;
      s3_sum[3] = u1_i;
      s3_sum[4] = u2_r;
      s3_sum[5] = u2_i;
      s3_sum[6] = u3_r;
      s3_sum[7] = u3_i;
    end else begin
      s3_sum[0] = u0_r + u2_r;
      s3_sum[1] = u0_i + u2_i;
      s3_sum[4] = u0_r - u2_r;
      s3_sum[5] = u0_i - u2_i;
      // u1 = a-c, u3 = b-d; -j*u3 = (u3_i, -u3_r)
      if (!s2_inv) begin
        s3_sum[2] = u1_r + u3_i;
        s3_sum[3] = u1_i - u3_r;
        s3_sum[6] = u1_r - u3_i;
        s3_sum[7] = u1_i + u3_r;
      end else begin
        s3_sum[2] = u1_r - u3_i;
        s3_sum[3] = u1_i + u3_r;
        s3_sum[6] = u1_r + u3_i;
        s3_sum[7] = u1_i - u3_r;
      end
    end
  end

  always_comb begin
    s3_clip = '0;
    for (int i = 0; i < 8; i++) begin
      case (s2_scale)
        2'd0:    s3_scl[i] = s3_sum[i];
        2'd1:    s3_scl[i] = (s3_sum[i] + SW'(1)) >>> 1;
        default: s3_scl[i] = (s3_sum[i] + SW'(2)) >>> 2;
      endcase
      if (s3_scl[i] > Q_MAX) begin
        s3_q[i]    = Q_MAX[OUT_WIDTH-1:0];
        s3_clip[i] = 1'b1;
      end else if (s3_scl[i] < Q_MIN) begin
        s3_q[i]    = Q_MIN[OUT_WIDTH-1:0];
        s3_clip[i] = 1'b1;
      end else begin
        s3_q[i]    = s3_scl[i][OUT_WIDTH-1:0];
      end
    end
    ovf_set = !stall && s2_valid && (|s3_clip);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      Q0_r <= '0;
      Q0_i <= '0;
      Q1_r <= '0;
      Q1_i <= '0;
      Q2_r <= '0;
      Q2_i <= '0;
      Q3_r <= '0;
      Q3_i <= '0;
    end else begin
      // a new clip wins over a simultaneous clear
      ovf <= ovf_set | (ovf & ~ovf_clr);
      if (!stall) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          Q0_r <= s3_q[0];
          Q0_i <= s3_q[1];
          Q1_r <= s3_q[2];
          Q1_i <= s3_q[3];
          Q2_r <= s3_q[4];
          Q2_i <= s3_q[5];
          Q3_r <= s3_q[6];
          Q3_i <= s3_q[7];
        end
      end
    end
  end

endmodule
